// File: rtl/eth_10g_st_pkg.sv
// Shared helpers and types for the 10G MAC Avalon-ST timing adapter.
package eth_10g_st_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Pointer width: one extra MSB to tell full from empty.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic sop;
        logic eop;
    } pkt_sb_t;

endpackage

// File: rtl/eth_10g_st_timing_adapter_fifo_if.sv
// Source-side and sink-side Avalon-ST signals of the timing adapter.
// Packet sideband exists only when ST_TIMING_ADAPTER_PKT_EN is defined.
interface eth_10g_st_timing_adapter_fifo_if #(
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
`ifdef ST_TIMING_ADAPTER_PKT_EN
    logic              in_sop;
    logic              in_eop;
    logic              out_sop;
    logic              out_eop;

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop
    );
    modport master (
        output in_valid, in_data, in_sop, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop
    );
`else
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/eth_10g_sync_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy.
// mark_last sets bit 0 of the most recently written entry (used to force eop).
module eth_10g_sync_fwft_fifo
    import eth_10g_st_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      pop,
    input  logic                      mark_last,
    output logic [WIDTH-1:0]          rdata,
    output logic                      full,
    output logic                      empty,
    output logic [ptr_w(DEPTH)-1:0]   fill_level
);
    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned AW    = PTR_W - 1;
    localparam logic [PTR_W-1:0] PTR_MSB = PTR_W'(1) << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] last_ptr;

    assign last_ptr = wr_ptr - PTR_W'(1);
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = ((wr_ptr ^ rd_ptr) == PTR_MSB);
    assign rdata    = mem[rd_ptr[AW-1:0]];

    // Pointers wrap modulo 2*DEPTH; occupancy tracked alongside.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fill_level <= fill_level + PTR_W'(push) - PTR_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (push)                mem[wr_ptr[AW-1:0]]      <= wdata;
            if (mark_last && !empty) mem[last_ptr[AW-1:0]][0] <= 1'b1;
        end
    end

endmodule

// File: rtl/eth_10g_st_timing_adapter_fifo.sv
// Avalon-ST timing adapter: FWFT buffer with overflow drop/count for 10G MAC paths.
// Define ST_TIMING_ADAPTER_PKT_EN for sop/eop sideband and packet-drop FSM.
module eth_10g_st_timing_adapter_fifo
    import eth_10g_st_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned IN_READY_EN = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    eth_10g_st_timing_adapter_fifo_if.slave   st,
    output logic [ptr_w(DEPTH)-1:0]           fill_level,
    output logic                              overflow_pulse,
    output logic [CNT_W-1:0]                  overflow_cnt,
    input  logic                              clear_cnt
);
    localparam int unsigned PTR_W = ptr_w(DEPTH);
`ifdef ST_TIMING_ADAPTER_PKT_EN
    localparam int unsigned PAY_W = DATA_W + 2;
`else
    localparam int unsigned PAY_W = DATA_W;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             pop;
    logic             push;
    logic             drop;
    logic             acc;
    logic             full;
    logic             empty;
    logic             mark_last;
    logic             in_ready_q;
    logic [PTR_W-1:0] fill_nxt;
    logic [PAY_W-1:0] wdata;
    logic [PAY_W-1:0] rdata;

    // Without source backpressure a same-cycle pop frees the slot for the incoming beat.
    assign pop      = ~empty & st.out_ready;
    assign acc      = (IN_READY_EN != 0) ? in_ready_q : ~(full & ~pop);
    assign fill_nxt = fill_level + PTR_W'(push) - PTR_W'(pop);

    assign st.in_ready  = in_ready_q;
    assign st.out_valid = ~empty;

`ifdef ST_TIMING_ADAPTER_PKT_EN
    typedef enum logic {S_IDLE, S_DROP} state_t;

    state_t  state;
    pkt_sb_t sb_in;
    pkt_sb_t sb_out;
    logic    gate;

    assign sb_in       = '{sop: st.in_sop, eop: st.in_eop};
    assign wdata       = {st.in_data, sb_in};
    assign sb_out      = pkt_sb_t'(rdata[1:0]);
    assign st.out_data = rdata[PAY_W-1:2];
    assign st.out_sop  = sb_out.sop;
    assign st.out_eop  = sb_out.eop;

    // In DROP only a new sop may re-enter; first drop terminates the buffered packet.
    assign gate      = (state == S_IDLE) | st.in_sop;
    assign push      = st.in_valid & gate & acc;
    assign drop      = st.in_valid & ~push;
    assign mark_last = drop & (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else if (drop) begin
            state <= S_DROP;
        end else if (push) begin
            state <= S_IDLE;
        end
    end
`else
    assign wdata       = st.in_data;
    assign st.out_data = rdata;
    assign push        = st.in_valid & acc;
    assign drop        = st.in_valid & ~acc;
    assign mark_last   = 1'b0;
`endif

    eth_10g_sync_fwft_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .wdata      (wdata),
        .pop        (pop),
        .mark_last  (mark_last),
        .rdata      (rdata),
        .full       (full),
        .empty      (empty),
        .fill_level (fill_level)
    );

    // Ready tracks next-cycle fullness; low through reset in backpressure mode.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_ready_q     <= (IN_READY_EN == 0);
            overflow_pulse <= 1'b0;
            overflow_cnt   <= '0;
        end else begin
            in_ready_q     <= (IN_READY_EN == 0) || (fill_nxt != PTR_W'(DEPTH));
            overflow_pulse <= drop;
            if (clear_cnt) begin
                overflow_cnt <= '0;
            end else if (drop && (overflow_cnt != CNT_MAX)) begin
                overflow_cnt <= overflow_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && (IN_READY_EN != 0)) begin
            assert (!(st.in_valid && !in_ready_q))
                else $error("in_valid asserted while in_ready is low");
        end
    end

endmodule

// File: doc/eth_10g_st_timing_adapter_fifo.md
Name: eth_10g_st_timing_adapter_fifo

Overview:
Parametrised Avalon-ST timing adapter for the 10G MAC RX/TX paths, replacing the fixed 16-bit pass-through adapters.
- Inserts a small first-word-fall-through (FWFT) buffer between a source and a sink.
- Absorbs sink backpressure when the source cannot be stalled.
- In that mode, drops and counts overflow beats instead of silently losing them.
- Optionally exposes ready to sources that do support backpressure.

Parameters:
DATA_W, 16, payload width in bits (1..256)
DEPTH, 4, buffer entries; power of two, 2..64
IN_READY_EN, 0, 1 = source honours in_ready (ready latency 0); 0 = source cannot be backpressured
CNT_W, 16, width of the overflow counter

Ports:
clk  in  1  single clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
in_valid  in  1  source beat valid
in_data  in  DATA_W  source payload
in_ready  out  1  not full; constant 1 when IN_READY_EN=0
out_valid  out  1  buffer not empty
out_data  out  DATA_W  head-of-buffer payload
out_ready  in  1  sink ready, ready latency 0
fill_level  out  clog2(DEPTH)+1  current occupancy
overflow_pulse  out  1  one-cycle pulse per dropped beat
overflow_cnt  out  CNT_W  saturating count of dropped beats
clear_cnt  in  1  synchronous clear of overflow_cnt

Behaviour:
- Reset (reset_n=0 at a clock edge) sets:
  - pointers and fill_level to 0, so out_valid=0
  - overflow_pulse=0, overflow_cnt=0
  - in_ready=0 when IN_READY_EN=1; in_ready=1 otherwise
  - out_data is don't-care while out_valid=0
- Reset asserted mid-operation discards buffered beats. No output beat is produced in the cycle after reset.
- Push condition: in_valid & ~full, where full means fill_level==DEPTH.
- Pop condition: out_valid & out_ready.
- Latency:
  - A beat pushed at edge N is visible on out_valid/out_data after edge N (one-cycle latency).
  - There is no combinational in_* to out_* path.
- FWFT: out_data always reflects the entry at rd_ptr. It is held stable while out_valid=1 and out_ready=0 (Avalon-ST rule).
- Pointers are clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - Empty: wr_ptr==rd_ptr.
  - Full: pointers differ only in the MSB.
- Simultaneous push and pop:
  - Not full: both occur; fill_level is unchanged.
  - At full, with IN_READY_EN=0: the pop frees the slot combinationally, so the incoming beat is accepted and not dropped. Full for push purposes is fill_level==DEPTH & ~pop.
  - At full, with IN_READY_EN=1: in_ready=~full is registered-derived and does not include pop. The source therefore sees in_ready=0; no drop is possible.
- Overflow (IN_READY_EN=0 only): in_valid while effectively full causes:
  - the beat is discarded;
  - overflow_pulse=1 in the next cycle;
  - overflow_cnt increments, saturating at all-ones.
- clear_cnt has priority over increment in the same cycle.
- A protocol violation (in_valid while in_ready=0 with IN_READY_EN=1) is treated as a dropped beat and counted. It fires a simulation-only assertion.
- Empty with in_valid: out_valid rises the next cycle; there is no bypass.

Optional Feature:
ST_TIMING_ADAPTER_PKT_EN
- Defined:
  - Adds ports in_sop, in_eop, out_sop, out_eop, carried in the payload alongside in_data.
  - Adds a DROP state. On the first overflow inside a packet, the FSM moves IDLE->DROP. In DROP, all beats are discarded and counted until a beat with in_sop=1 arrives; that beat is treated normally and the FSM returns to IDLE.
  - The buffered partial packet already in the buffer is forced to terminate: the last written entry has its eop bit set at the drop moment. If no entry exists, nothing is forced.
- Undefined: no sop/eop ports and no FSM; overflow drops single beats only.

Decomposition:
- Package eth_10g_st_pkg holds:
  - function clog2
  - localparam PTR_W rule
  - typedef for the packet sideband struct {sop, eop}
- One sub-module, eth_10g_sync_fwft_fifo:
  - memory, pointers and fill_level
  - push/pop inputs, full/empty outputs
- The top level holds ready/valid mapping, overflow counting and the optional drop FSM.

Test Plan:
- Pass-through, DATA_W=16, DEPTH=4, out_ready=1, in_data 0x0001..0x0010 every cycle:
  - each beat appears one cycle later, in order;
  - fill_level stays ≤1;
  - overflow_cnt=0.
- Backpressure absorb, IN_READY_EN=0: out_ready=0 for 4 cycles with 4 beats 0xA0..0xA3, then out_ready=1:
  - fill_level reaches 4;
  - 0xA0..0xA3 are delivered in order;
  - no overflow.
- Overflow, IN_READY_EN=0: 6 beats with out_ready=0:
  - beats 5 and 6 are dropped;
  - overflow_pulse fires twice;
  - overflow_cnt=2;
  - out delivers the first 4.
- Full with simultaneous pop, IN_READY_EN=0: fill 4, then in_valid and out_ready together:
  - no drop;
  - fill_level stays 4;
  - the new beat is delivered last.
- IN_READY_EN=1: sink stalls for 10 cycles:
  - in_ready falls after 4 accepted beats;
  - zero drops;
  - in_ready rises one cycle after the first pop.
- Reset mid-stream with 3 beats buffered, reset_n=0 for 1 cycle:
  - out_valid=0 and fill_level=0 next cycle;
  - counter cleared;
  - saturation check with CNT_W=4: after 20 drops, cnt=15.
